// File: rtl/hilo_muldiv_unit.sv
// Iterative Hi/Lo multiply/divide unit: WIDTH shift steps plus one sign-fix cycle.
// Build option: define HILO_MADD_EN to enable MADD/MSUB accumulation into Hi/Lo.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A_IN,
   input  logic [WIDTH-1:0] B_IN,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             Busy,
   output logic             Done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [2:0] OP_MULT = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_DIVU = 3'b011;
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;
`ifdef HILO_MADD_EN
   localparam logic [2:0] OP_MADD = 3'b110;
   localparam logic [2:0] OP_MSUB = 3'b111;
`endif

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] ph_q, ph_d, pl_q, pl_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d, rneg_q, rneg_d;
   logic             div0_q, div0_d, done_q, done_d;

   logic               multi_in, signed_in, a_neg, b_neg, run_div;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_s, rem_s;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] prod, prod_s;

`ifdef HILO_MADD_EN
   assign multi_in = 1'b1;
`else
   assign multi_in = ~Op[2];
`endif

   assign signed_in = (Op == OP_MULT) | (Op == OP_DIV) | (Op[2:1] == 2'b11);
   assign a_neg     = signed_in & A_IN[WIDTH-1];
   assign b_neg     = signed_in & B_IN[WIDTH-1];
   assign a_mag     = a_neg ? -A_IN : A_IN;
   assign b_mag     = b_neg ? -B_IN : B_IN;

   assign run_div  = (op_q == OP_DIV) | (op_q == OP_DIVU);
   assign mul_sum  = {1'b0, ph_q} + (pl_q[0] ? {1'b0, b_q} : '0);
   assign div_sh   = {ph_q, pl_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, b_q};

   assign prod   = {ph_q, pl_q};
   assign prod_s = neg_q ? -prod : prod;
   assign quo_s  = neg_q ? -pl_q : pl_q;
   assign rem_s  = rneg_q ? -ph_q : ph_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ph_d    = ph_q;
      pl_d    = pl_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div0_d  = div0_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               if (Op == OP_MTHI) begin
                  hi_d = A_IN;
               end else if (Op == OP_MTLO) begin
                  lo_d = A_IN;
               end else if (multi_in) begin
                  op_d    = Op;
                  ph_d    = '0;
                  pl_d    = a_mag;
                  b_d     = b_mag;
                  neg_d   = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  div0_d  = (B_IN == '0);
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Restoring divide: keep the shifted value when the trial subtract borrows.
            if (run_div) begin
               if (!div_diff[WIDTH]) begin
                  ph_d = div_diff[WIDTH-1:0];
                  pl_d = {pl_q[WIDTH-2:0], 1'b1};
               end else begin
                  ph_d = div_sh[WIDTH-1:0];
                  pl_d = {pl_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               {ph_d, pl_d} = {mul_sum, pl_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            if (run_div) begin
               hi_d = rem_s;
               lo_d = div0_q ? '1 : quo_s;
            end
`ifdef HILO_MADD_EN
            else if (op_q == OP_MADD) begin
               {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            end else if (op_q == OP_MSUB) begin
               {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            end
`endif
            else begin
               {hi_d, lo_d} = prod_s;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ph_q    <= '0;
         pl_q    <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
         done_q  <= done_d;
      end
   end

   assign HiOut = hi_q;
   assign LoOut = lo_q;
   assign Busy  = (state_q != IDLE);
   assign Done  = done_q;
endmodule
